// File: rtl/cia_bus.sv
// CIA host-bus front end: synchronises and filters the raw bus pins, tracks the PHI2 phase,
// and captures the register access (rd/we/addr/data) plus the data-bus output enable.

module cia_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic res_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

module cia_bus #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_i,
    input  logic       cs_n_i,
    input  logic       rw_i,
    input  logic [3:0] rs_i,
    input  logic [7:0] db_i,
    output logic       phi2,
    output logic       phi2_up,
    output logic       phi2_dn,
    output logic       rd,
    output logic       we,
    output logic [3:0] addr,
    output logic [7:0] data,
    output logic       db_oe
);
    typedef struct packed {
        logic [7:0] db;
        logic [3:0] rs;
        logic       rw;
        logic       cs_n;
        logic       phi2;
    } pins_t;

    typedef enum logic [1:0] {INIT, LOW, HIGH} state_t;

    localparam int          PW       = $bits(pins_t);
    localparam logic [2:0]  FLT_LAST = 3'(FILTER - 1);

    pins_t                  pin_raw;
    pins_t                  pin_s;
    state_t                 state;
    logic [2:0]             cnt;
    logic [7:0]             dbuf;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   p_s;
    logic                   s_vld;
    logic                   accept;

    assign pin_raw = '{db: db_i, rs: rs_i, rw: rw_i, cs_n: cs_n_i, phi2: phi2_i};

    for (genvar i = 0; i < PW; i++) begin : g_sync
        cia_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .res_n (res_n),
            .d     (pin_raw[i]),
            .q     (pin_s[i])
        );
    end

    assign p_s    = pin_s.phi2;
    assign accept = (p_s != phi2) && (cnt == FLT_LAST);

    // The synchroniser resets to 0, so p_s is not a real pin sample until
    // the pipe has refilled; without this a pin held high at release would
    // look like a low and let INIT skip straight to LOW.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
    assign s_vld = vld_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)                    cnt <= '0;
        else if (p_s == phi2 || accept) cnt <= '0;
        else                           cnt <= cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)   dbuf <= '0;
        else if (p_s) dbuf <= pin_s.db;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= INIT;
            phi2    <= 1'b0;
            phi2_up <= 1'b0;
            phi2_dn <= 1'b0;
            rd      <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            data    <= '0;
            db_oe   <= 1'b0;
        end else begin
            phi2_up <= 1'b0;
            phi2_dn <= 1'b0;
            db_oe   <= rd & phi2;
            if (phi2_dn) begin
                rd <= 1'b0;
                we <= 1'b0;
            end
            // A capture below must win over the clear above when FILTER=1
            // lets a rise be accepted right after a fall.
            case (state)
                INIT: begin
                    if (accept) begin
                        phi2 <= p_s;
                        if (!p_s) state <= LOW;
                    end else if (s_vld && !phi2 && !p_s) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (accept) begin
                        phi2    <= 1'b1;
                        phi2_up <= 1'b1;
                        addr    <= pin_s.rs;
                        rd      <= ~pin_s.cs_n &  pin_s.rw;
                        we      <= ~pin_s.cs_n & ~pin_s.rw;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (accept) begin
                        phi2    <= 1'b0;
                        phi2_dn <= 1'b1;
                        data    <= dbuf;
                        state   <= LOW;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_cia_bus.sv
// Directed bench for cia_bus: expected strobes and access fields are queued
// when a PHI2 edge is driven and checked when the strobe shows up.

module tb_cia_bus;
    logic       clk;
    logic       res_n;
    logic       phi2_i;
    logic       cs_n_i;
    logic       rw_i;
    logic [3:0] rs_i;
    logic [7:0] db_i;
    logic       phi2;
    logic       phi2_up;
    logic       phi2_dn;
    logic       rd;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       db_oe;

    cia_bus dut (
        .clk     (clk),
        .res_n   (res_n),
        .phi2_i  (phi2_i),
        .cs_n_i  (cs_n_i),
        .rw_i    (rw_i),
        .rs_i    (rs_i),
        .db_i    (db_i),
        .phi2    (phi2),
        .phi2_up (phi2_up),
        .phi2_dn (phi2_dn),
        .rd      (rd),
        .we      (we),
        .addr    (addr),
        .data    (data),
        .db_oe   (db_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         up;
        int         cyc;
        logic       rd;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests;
    int   n_fail;
    int   cyc;
    bit   active;
    bit   post_dn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("dual_strobe", 32'(phi2_up & phi2_dn), 0);
        if (post_dn) begin
            chk("rd_after_dn", 32'(rd), 0);
            chk("we_after_dn", 32'(we), 0);
            chk("oe_after_dn", 32'(db_oe), 0);
            post_dn = 0;
        end
        if (phi2_up || phi2_dn) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'({phi2_up, phi2_dn}), 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", 32'({phi2_up, phi2_dn}), e.up ? 32'd2 : 32'd1);
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                if (e.up) begin
                    cur    = e;
                    active = 1;
                    chk("oe_at_up", 32'(db_oe), 0);
                end else begin
                    chk("data_at_dn", 32'(data), 32'(e.data));
                    post_dn = 1;
                end
            end
        end
        if (active) begin
            chk("rd_hold", 32'(rd), 32'(cur.rd));
            chk("we_hold", 32'(we), 32'(cur.we));
            chk("addr_hold", 32'(addr), 32'(cur.addr));
            if (phi2 && !phi2_up) chk("oe_high", 32'(db_oe), 32'(cur.rd));
        end
        if (phi2_dn) active = 0;
    endtask

    task automatic push(input bit up, input logic cs, input logic rw, input logic [3:0] rs,
                        input logic [7:0] db);
        exp_t e;
        e.up   = up;
        e.cyc  = cyc + 4;
        e.rd   = ~cs & rw;
        e.we   = ~cs & ~rw;
        e.addr = rs;
        e.data = db;
        sb.push_back(e);
    endtask

    // Full 16-clock PHI2 cycle; optionally disturbs /CS, R/W, RS mid-high.
    task automatic bus_cycle(input logic cs, input logic rw, input logic [3:0] rs,
                             input logic [7:0] db, input bit flip);
        cs_n_i = cs; rw_i = rw; rs_i = rs; db_i = db; phi2_i = 1'b1;
        push(1, cs, rw, rs, db);
        repeat (4) tick();
        if (flip) begin
            cs_n_i = ~cs; rw_i = ~rw; rs_i = ~rs;
        end
        repeat (4) tick();
        phi2_i = 1'b0;
        push(0, cs, rw, rs, db);
        tick();
        db_i = ~db; cs_n_i = 1'b1;
        repeat (7) tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; active = 0; post_dn = 0;
        res_n = 1'b0; phi2_i = 1'b0; cs_n_i = 1'b1; rw_i = 1'b1; rs_i = '0; db_i = '0;
        repeat (3) tick();
        chk("rst_phi2", 32'(phi2), 0);
        chk("rst_oe", 32'(db_oe), 0);
        res_n = 1'b1;
        repeat (20) tick();
        chk("pre_phi2", 32'(phi2), 0);
        chk("pre_strobes", 32'({phi2_up, phi2_dn}), 0);
        chk("pre_rd_we", 32'({rd, we}), 0);
        chk("pre_addr", 32'(addr), 0);
        chk("pre_data", 32'(data), 0);
        chk("pre_oe", 32'(db_oe), 0);

        // write, read, deselected, then accesses disturbed mid-high
        bus_cycle(1'b0, 1'b0, 4'h1, 8'hA5, 0);
        bus_cycle(1'b0, 1'b1, 4'hD, 8'h3C, 0);
        bus_cycle(1'b1, 1'b0, 4'h7, 8'h5A, 0);
        bus_cycle(1'b0, 1'b0, 4'h9, 8'hC3, 1);
        bus_cycle(1'b0, 1'b1, 4'h2, 8'h81, 1);
        chk("addr_held", 32'(addr), 32'h2);
        chk("data_held", 32'(data), 32'h81);

        // glitch in LOW
        phi2_i = 1'b1; tick(); phi2_i = 1'b0;
        repeat (5) tick();
        chk("glitch_lo_phi2", 32'(phi2), 0);
        chk("glitch_lo_cnt", 32'(dut.cnt), 0);

        // dropout in HIGH during a write
        cs_n_i = 1'b0; rw_i = 1'b0; rs_i = 4'h6; db_i = 8'h6E; phi2_i = 1'b1;
        push(1, 1'b0, 1'b0, 4'h6, 8'h6E);
        repeat (8) tick();
        phi2_i = 1'b0; tick(); phi2_i = 1'b1;
        repeat (5) tick();
        chk("glitch_hi_phi2", 32'(phi2), 1);
        chk("glitch_hi_cnt", 32'(dut.cnt), 0);
        phi2_i = 1'b0;
        push(0, 1'b0, 1'b0, 4'h6, 8'h6E);
        repeat (8) tick();

        // reset in the middle of a read
        cs_n_i = 1'b0; rw_i = 1'b1; rs_i = 4'hB; db_i = 8'h17; phi2_i = 1'b1;
        push(1, 1'b0, 1'b1, 4'hB, 8'h17);
        repeat (8) tick();
        chk("mid_rd_before", 32'({rd, db_oe}), 32'h3);
        res_n = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(rd), 0);
        chk("mid_rst_oe", 32'(db_oe), 0);
        chk("mid_rst_phi2", 32'(phi2), 0);
        sb.delete(); active = 0; post_dn = 0;
        repeat (3) tick();
        res_n = 1'b1;
        repeat (12) tick();
        chk("rel_high_nostrobe", 32'(sb.size()), 0);
        phi2_i = 1'b0;
        repeat (10) tick();
        chk("rel_low_phi2", 32'(phi2), 0);
        push(1, 1'b0, 1'b1, 4'hB, 8'h17);
        phi2_i = 1'b1;
        repeat (8) tick();
        phi2_i = 1'b0;
        push(0, 1'b0, 1'b1, 4'hB, 8'h17);
        repeat (8) tick();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
